// File: rtl/aes_decipher_seq.sv
// Round sequencer and state register for the AES decipher datapath (init, main, final rounds).
// Define AES_DECIPHER_SEQ_AES192_EN to accept keylen = 1 (AES-192); otherwise it is rejected.
module aes_decipher_seq #(
  parameter int unsigned NR128 = 10,
  parameter int unsigned NR192 = 12,
  parameter int unsigned NR256 = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         key_ready,
  input  logic [1:0]   keylen,
  input  logic [127:0] block,
  input  logic [127:0] new_block,
  output logic [127:0] round_block,
  output logic [1:0]   round_type,
  output logic [3:0]   round_key_addr,
  output logic         ready,
  output logic [127:0] result,
  output logic         result_valid,
  output logic         keylen_err
);

  localparam logic [1:0] RoundInit  = 2'd0;
  localparam logic [1:0] RoundMain  = 2'd1;
  localparam logic [1:0] RoundFinal = 2'd2;

  typedef enum logic [1:0] {StIdle, StInit, StMain, StFinal} state_e;

  state_e       state_q, state_d;
  logic [127:0] block_q, block_d;
  logic [127:0] result_q, result_d;
  logic [3:0]   nr_q, nr_d;
  logic [3:0]   ctr_q, ctr_d;
  logic         ready_q, ready_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  logic         keylen_ok;
  logic [3:0]   keylen_nr;

  // Round count for the requested key length; unsupported lengths leave keylen_ok low.
  always_comb begin
    keylen_ok = 1'b0;
    keylen_nr = 4'd0;
    case (keylen)
      2'd0: begin
        keylen_ok = 1'b1;
        keylen_nr = 4'(NR128);
      end
`ifdef AES_DECIPHER_SEQ_AES192_EN
      2'd1: begin
        keylen_ok = 1'b1;
        keylen_nr = 4'(NR192);
      end
`endif
      2'd2: begin
        keylen_ok = 1'b1;
        keylen_nr = 4'(NR256);
      end
      default: begin
        keylen_ok = 1'b0;
        keylen_nr = 4'd0;
      end
    endcase
  end

`ifndef AES_DECIPHER_SEQ_AES192_EN
  logic unused_nr192;
  assign unused_nr192 = ^NR192;
`endif

  always_comb begin
    state_d        = state_q;
    block_d        = block_q;
    result_d       = result_q;
    nr_d           = nr_q;
    ctr_d          = ctr_q;
    ready_d        = ready_q;
    valid_d        = valid_q;
    err_d          = 1'b0;
    round_type     = RoundInit;
    round_key_addr = 4'd0;

    case (state_q)
      StIdle: begin
        // Starts without valid round keys are dropped silently.
        if (next && ready_q && key_ready) begin
          if (keylen_ok) begin
            block_d = block;
            nr_d    = keylen_nr;
            ctr_d   = keylen_nr;
            ready_d = 1'b0;
            valid_d = 1'b0;
            state_d = StInit;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StInit: begin
        round_type     = RoundInit;
        round_key_addr = nr_q;
        block_d        = new_block;
        ctr_d          = nr_q - 4'd1;
        state_d        = StMain;
      end

      StMain: begin
        round_type     = RoundMain;
        round_key_addr = ctr_q;
        block_d        = new_block;
        ctr_d          = ctr_q - 4'd1;
        if (ctr_q == 4'd1) begin
          state_d = StFinal;
        end
      end

      StFinal: begin
        round_type     = RoundFinal;
        round_key_addr = 4'd0;
        result_d       = new_block;
        valid_d        = 1'b1;
        ready_d        = 1'b1;
        state_d        = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      block_q  <= '0;
      result_q <= '0;
      nr_q     <= '0;
      ctr_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      block_q  <= block_d;
      result_q <= result_d;
      nr_q     <= nr_d;
      ctr_q    <= ctr_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign round_block  = block_q;
  assign ready        = ready_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign keylen_err   = err_q;

endmodule
